// File: rtl/avl_fb_pkg.sv
// Shared register map and bit positions for the Avalon-MM frame buffer.
package avl_fb_pkg;

    localparam int unsigned CSR_CTRL   = 0;
    localparam int unsigned CSR_STATUS = 1;
    localparam int unsigned CSR_RESULT = 2;
    localparam int unsigned BUF_BASE   = 3;

    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;

    // One past the last mapped word address.
    function automatic int unsigned map_words(input int unsigned depth);
        return depth + BUF_BASE;
    endfunction

endpackage

// File: rtl/avl_fb_be_ram.sv
// Byte-enabled buffer RAM: one write port, two registered read ports, no reset.
module avl_fb_be_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 400,
    parameter int IDX_W  = 9
) (
    input  logic                CLK,
    input  logic                WE,
    input  logic [IDX_W-1:0]    W_IDX,
    input  logic [DATA_W/8-1:0] BYTE_EN,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [IDX_W-1:0]    A_IDX,
    output logic [DATA_W-1:0]   A_RDATA,
    input  logic [IDX_W-1:0]    B_IDX,
    output logic [DATA_W-1:0]   B_RDATA
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads sample the array before this edge's write lands: read-old-data.
    always_ff @(posedge CLK) begin
        if (WE) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (BYTE_EN[i]) mem[W_IDX][i*8 +: 8] <= WDATA[i*8 +: 8];
            end
        end
        A_RDATA <= mem[A_IDX];
        B_RDATA <= mem[B_IDX];
    end

endmodule

// File: rtl/avl_mm_frame_buffer.sv
// Avalon-MM slave fronting a frame buffer and the control/status registers
// of a detection core that reads the buffer through its own port.
module avl_mm_frame_buffer
    import avl_fb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                AVL_CS,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic [ADDR_W-1:0]   AVL_ADDR,
    input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
    input  logic [DATA_W-1:0]   AVL_WRITEDATA,
    output logic [DATA_W-1:0]   AVL_READDATA,
    output logic                AVL_READDATAVALID,
    output logic                CORE_START,
    input  logic                CORE_DONE,
    input  logic [DATA_W-1:0]   CORE_RESULT,
    input  logic [ADDR_W-1:0]   CORE_ADDR,
    output logic [DATA_W-1:0]   CORE_RDATA,
    output logic                IRQ
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              host_wr, host_rd, buf_hit, core_hit;
    logic              ctrl_wr, status_wr, start_req, core_fin;
    logic [IDX_W-1:0]  host_idx, core_idx;
    logic [DATA_W-1:0] csr_rdata, ram_a_rdata, ram_b_rdata;
    logic              busy_q, done_q, irq_en_q;
    logic [DATA_W-1:0] result_q;
    logic              rvalid_q, rsel_buf_q, core_ok_q;
    logic [DATA_W-1:0] rreg_q;

    // Host side has no backpressure: every CS&READ is answered with
    // READDATAVALID exactly one cycle later; CS&WRITE completes in its cycle.
    assign host_wr   = AVL_CS & AVL_WRITE;
    assign host_rd   = AVL_CS & AVL_READ;
    assign buf_hit   = (AVL_ADDR >= ADDR_W'(BUF_BASE)) && (32'(AVL_ADDR) < map_words(DEPTH));
    assign host_idx  = buf_hit ? IDX_W'(AVL_ADDR - ADDR_W'(BUF_BASE)) : '0;
    assign core_hit  = 32'(CORE_ADDR) < DEPTH;
    assign core_idx  = core_hit ? CORE_ADDR[IDX_W-1:0] : '0;

    assign ctrl_wr   = host_wr && (AVL_ADDR == ADDR_W'(CSR_CTRL))   && AVL_BYTE_EN[0];
    assign status_wr = host_wr && (AVL_ADDR == ADDR_W'(CSR_STATUS)) && AVL_BYTE_EN[0];
    assign start_req = ctrl_wr && AVL_WRITEDATA[CTRL_START_BIT] && !busy_q;
    assign core_fin  = CORE_DONE && busy_q;

    always_comb begin
        csr_rdata = '0;
        if (AVL_ADDR == ADDR_W'(CSR_CTRL)) begin
            csr_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (AVL_ADDR == ADDR_W'(CSR_STATUS)) begin
            csr_rdata[STATUS_BUSY_BIT] = busy_q;
            csr_rdata[STATUS_DONE_BIT] = done_q;
        end else if (AVL_ADDR == ADDR_W'(CSR_RESULT)) begin
            csr_rdata = result_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            result_q   <= '0;
            CORE_START <= 1'b0;
        end else begin
            CORE_START <= start_req;
            if (ctrl_wr) irq_en_q <= AVL_WRITEDATA[CTRL_IRQ_EN_BIT];
            if (start_req) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else if (core_fin) begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= CORE_RESULT;
            end else if (status_wr && AVL_WRITEDATA[STATUS_DONE_BIT]) begin
                done_q <= 1'b0;
            end
        end
    end

    // Read-side qualifiers carry the reset so a pending response is dropped
    // and both read buses show 0 regardless of the unreset RAM outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rvalid_q   <= 1'b0;
            rsel_buf_q <= 1'b0;
            rreg_q     <= '0;
            core_ok_q  <= 1'b0;
        end else begin
            rvalid_q  <= host_rd;
            core_ok_q <= core_hit;
            if (host_rd) begin
                rsel_buf_q <= buf_hit;
                rreg_q     <= csr_rdata;
            end
        end
    end

    assign AVL_READDATA      = rsel_buf_q ? ram_b_rdata : rreg_q;
    assign AVL_READDATAVALID = rvalid_q;
    assign CORE_RDATA        = core_ok_q ? ram_a_rdata : '0;
    assign IRQ               = done_q & irq_en_q;

    avl_fb_be_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .CLK     (CLK),
        .WE      (host_wr && buf_hit && !busy_q),
        .W_IDX   (host_idx),
        .BYTE_EN (AVL_BYTE_EN),
        .WDATA   (AVL_WRITEDATA),
        .A_IDX   (core_idx),
        .A_RDATA (ram_a_rdata),
        .B_IDX   (host_idx),
        .B_RDATA (ram_b_rdata)
    );

endmodule

// File: tb/tb_avl_mm_frame_buffer.sv
// Self-checking bench for avl_mm_frame_buffer: read responses go through a
// scoreboard queue, control/core-port behaviour is checked directly.
module tb_avl_mm_frame_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 400;
    localparam int ADDR_W = 9;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              AVL_CS, AVL_READ, AVL_WRITE;
    logic [ADDR_W-1:0] AVL_ADDR;
    logic [3:0]        AVL_BYTE_EN;
    logic [31:0]       AVL_WRITEDATA, AVL_READDATA;
    logic              AVL_READDATAVALID, CORE_START, CORE_DONE, IRQ;
    logic [31:0]       CORE_RESULT, CORE_RDATA;
    logic [ADDR_W-1:0] CORE_ADDR;

    logic [31:0] exp_q [$];
    logic [31:0] model_mem [DEPTH];
    int n_vec = 0;
    int n_err = 0;

    avl_mm_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .AVL_CS            (AVL_CS),
        .AVL_READ          (AVL_READ),
        .AVL_WRITE         (AVL_WRITE),
        .AVL_ADDR          (AVL_ADDR),
        .AVL_BYTE_EN       (AVL_BYTE_EN),
        .AVL_WRITEDATA     (AVL_WRITEDATA),
        .AVL_READDATA      (AVL_READDATA),
        .AVL_READDATAVALID (AVL_READDATAVALID),
        .CORE_START        (CORE_START),
        .CORE_DONE         (CORE_DONE),
        .CORE_RESULT       (CORE_RESULT),
        .CORE_ADDR         (CORE_ADDR),
        .CORE_RDATA        (CORE_RDATA),
        .IRQ               (IRQ)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    // Driver tasks: entered and left at posedge+1.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic avl_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] be);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr;
        AVL_WRITEDATA = data; AVL_BYTE_EN = be;
        step();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0;
    endtask

    task automatic avl_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
        step();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    // Scoreboard: each response pops one expected word; a response with
    // nothing outstanding is itself a miscompare.
    always @(negedge CLK) begin
        if (AVL_READDATAVALID !== 1'b0) begin
            if (exp_q.size() == 0) check_val("spurious_rvalid", 32'(AVL_READDATAVALID), 32'h0);
            else                   check_val("rdata", AVL_READDATA, exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  be;
        RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
        AVL_ADDR = '0; AVL_BYTE_EN = '0; AVL_WRITEDATA = '0;
        CORE_DONE = 1'b0; CORE_RESULT = '0; CORE_ADDR = '0;
        #3;
        check_val("rst_readdata", AVL_READDATA, 32'h0);
        check_val("rst_rvalid", 32'(AVL_READDATAVALID), 32'h0);
        check_val("rst_core_start", 32'(CORE_START), 32'h0);
        check_val("rst_core_rdata", CORE_RDATA, 32'h0);
        check_val("rst_irq", 32'(IRQ), 32'h0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Byte-enable merge on buffer word 0
        avl_write(9'd3, 32'hDEADBEEF, 4'b1111);
        avl_write(9'd3, 32'h00001200, 4'b0010);
        model_mem[0] = 32'hDEAD12EF;
        avl_read(9'd3, 32'hDEAD12EF);
        idle(2);

        for (int i = 1; i < 8; i++) begin
            d = $urandom;
            avl_write(ADDR_W'(3 + i), d, 4'b1111);
            model_mem[i] = d;
        end
        for (int i = 1; i < 8; i++) begin
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            avl_write(ADDR_W'(3 + i), d, be);
            model_mem[i] = merge_be(model_mem[i], d, be);
        end
        avl_write(ADDR_W'(3 + DEPTH - 1), 32'h0BADF00D, 4'b1111);
        model_mem[DEPTH-1] = 32'h0BADF00D;
        for (int i = 1; i < 8; i++) avl_read(ADDR_W'(3 + i), model_mem[i]);
        avl_read(ADDR_W'(3 + DEPTH - 1), 32'h0BADF00D);
        idle(2);

        // Core read port
        CORE_ADDR = 9'd2;          step(); check_val("core_rd2", CORE_RDATA, model_mem[2]);
        CORE_ADDR = 9'(DEPTH - 1); step(); check_val("core_rd_last", CORE_RDATA, 32'h0BADF00D);
        CORE_ADDR = 9'(DEPTH);     step(); check_val("core_rd_oob", CORE_RDATA, 32'h0);
        CORE_ADDR = 9'd5;
        avl_write(9'd8, 32'h11112222, 4'b1111);
        check_val("core_rd_old", CORE_RDATA, model_mem[5]);
        model_mem[5] = 32'h11112222;
        step();
        check_val("core_rd_new", CORE_RDATA, 32'h11112222);

        // Back-to-back reads across the map and one unmapped word
        avl_read(9'd0, 32'h0);
        avl_read(9'd1, 32'h0);
        avl_read(9'd2, 32'h0);
        avl_read(9'd3, model_mem[0]);
        avl_read(9'd4, model_mem[1]);
        avl_read(9'd5, model_mem[2]);
        avl_read(9'(DEPTH + 3), 32'h0);
        idle(2);

        // Start / done / interrupt
        avl_write(9'd0, 32'h3, 4'b0001);
        check_val("start_pulse", 32'(CORE_START), 32'h1);
        step();
        check_val("start_pulse_end", 32'(CORE_START), 32'h0);
        avl_read(9'd1, 32'h1);
        avl_read(9'd0, 32'h2);
        idle(2);
        CORE_DONE = 1'b1; CORE_RESULT = 32'h0000002A;
        step();
        CORE_DONE = 1'b0;
        avl_read(9'd1, 32'h2);
        avl_read(9'd2, 32'h2A);
        idle(2);
        check_val("irq_set", 32'(IRQ), 32'h1);
        avl_write(9'd1, 32'h2, 4'b0001);
        check_val("irq_clr", 32'(IRQ), 32'h0);
        avl_read(9'd1, 32'h0);
        idle(2);

        // Start and buffer writes ignored while busy
        avl_write(9'd0, 32'h3, 4'b0001);
        step();
        avl_write(9'd0, 32'h3, 4'b0001);
        check_val("busy_no_start", 32'(CORE_START), 32'h0);
        avl_write(9'd3, 32'hCAFEF00D, 4'b1111);
        avl_read(9'd3, model_mem[0]);
        avl_read(9'd1, 32'h1);
        idle(2);

        // CORE_DONE and DONE W1C in the same cycle
        CORE_DONE = 1'b1; CORE_RESULT = 32'h55;
        avl_write(9'd1, 32'h2, 4'b0001);
        CORE_DONE = 1'b0;
        avl_read(9'd1, 32'h2);
        idle(2);
        check_val("irq_done_w1c", 32'(IRQ), 32'h1);
        CORE_DONE = 1'b1; CORE_RESULT = 32'h77;
        step();
        CORE_DONE = 1'b0;
        avl_read(9'd2, 32'h55);
        avl_read(9'd1, 32'h2);
        idle(2);

        // Asynchronous reset while busy, with a read response in flight
        avl_write(9'd0, 32'h3, 4'b0001);
        step();
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 9'd1;
        step();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        RESET = 1'b1;
        #1;
        check_val("arst_rvalid", 32'(AVL_READDATAVALID), 32'h0);
        check_val("arst_readdata", AVL_READDATA, 32'h0);
        check_val("arst_core_start", 32'(CORE_START), 32'h0);
        check_val("arst_core_rdata", CORE_RDATA, 32'h0);
        check_val("arst_irq", 32'(IRQ), 32'h0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        CORE_DONE = 1'b1; CORE_RESULT = 32'h99;
        step();
        CORE_DONE = 1'b0;
        avl_read(9'd1, 32'h0);
        avl_read(9'd2, 32'h0);
        avl_read(9'd0, 32'h0);
        idle(3);
        check_val("drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avl_mm_frame_buffer.md
AVL_MM_FRAME_BUFFER -- requirements
Module: avl_mm_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 400, number of buffer words.
REQ-003 SHALL have parameter ADDR_W, default 9, Avalon word-address width; SHALL satisfy 2^ADDR_W >= DEPTH+3.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 AVL_CS  in  1  chip select.
REQ-007 AVL_READ / AVL_WRITE  in  1 each  read / write strobes, valid only with AVL_CS.
REQ-008 AVL_ADDR  in  ADDR_W  word address.
REQ-009 AVL_BYTE_EN  in  DATA_W/8  per-byte write enable.
REQ-010 AVL_WRITEDATA  in  DATA_W  write data.
REQ-011 AVL_READDATA  out  DATA_W  registered read data.
REQ-012 AVL_READDATAVALID  out  1  qualifies AVL_READDATA.
REQ-013 CORE_START  out  1  one-cycle start pulse to detection core.
REQ-014 CORE_DONE  in  1  one-cycle completion pulse from core.
REQ-015 CORE_RESULT  in  DATA_W  core result, valid with CORE_DONE.
REQ-016 CORE_ADDR  in  ADDR_W  core buffer read index, 0-based.
REQ-017 CORE_RDATA  out  DATA_W  buffer word at CORE_ADDR, latency 1.
REQ-018 IRQ  out  1  level interrupt.

Function
REQ-019 Map: 0 CTRL (bit0 START write-only, bit1 IRQ_EN RW), 1 STATUS (bit0 BUSY RO, bit1 DONE W1C), 2 RESULT RO, 3..DEPTH+2 buffer words 0..DEPTH-1.
REQ-020 Host write accepted when AVL_CS & AVL_WRITE; each byte lane updated only where its AVL_BYTE_EN bit is 1; any enable pattern legal.
REQ-021 Host read accepted when AVL_CS & AVL_READ; AVL_READDATA and AVL_READDATAVALID=1 appear exactly one cycle later; READDATAVALID is 0 otherwise; no wait states; back-to-back reads every cycle.
REQ-022 Reads of unmapped addresses (>= DEPTH+3) return 0 with READDATAVALID=1; writes there are dropped.
REQ-023 CTRL reads return {0, IRQ_EN, 0}; START reads as 0.
REQ-024 Writing CTRL with bit0=1 (byte 0 enabled) while BUSY=0 SHALL assert CORE_START for exactly the next cycle and set BUSY; same write also clears DONE.
REQ-025 START write while BUSY=1 SHALL be ignored (no pulse, BUSY and DONE unchanged).
REQ-026 CORE_DONE while BUSY=1 SHALL clear BUSY, set DONE, capture CORE_RESULT into RESULT, same edge; CORE_DONE while BUSY=0 ignored.
REQ-027 DONE W1C write and CORE_DONE in same cycle: DONE SHALL end set.
REQ-028 Host buffer writes while BUSY=1 SHALL be dropped; host buffer reads always served.
REQ-029 IRQ SHALL equal registered DONE & IRQ_EN.
REQ-030 Host buffer read and core read in same cycle both served with latency 1; host write and core read of same word same cycle: core sees old data.
REQ-031 CORE_ADDR >= DEPTH returns 0 on CORE_RDATA.

Reset
REQ-032 On RESET: AVL_READDATA=0, AVL_READDATAVALID=0, CORE_START=0, CORE_RDATA=0, IRQ=0, BUSY=0, DONE=0, IRQ_EN=0, RESULT=0.
REQ-033 Buffer contents SHALL NOT be reset (RAM inference); undefined until written.
REQ-034 RESET mid-operation aborts: BUSY cleared, any pending read response discarded, later CORE_DONE ignored until a new START.

Structure
REQ-035 Package avl_fb_pkg SHALL hold address offsets (CTRL, STATUS, RESULT, BUF_BASE) and CTRL/STATUS bit indices.
REQ-036 Buffer SHALL be sub-module avl_fb_be_ram: one byte-enabled write port, two registered read ports, no reset.

Verification
REQ-037 Write 0xDEADBEEF to addr 3 BE=1111, then BE=0010 data 0x00001200, read addr 3 -> 0xDEAD12EF one cycle after read, READDATAVALID one cycle wide.
REQ-038 Write CTRL=0x3 -> CORE_START pulse 1 cycle, STATUS reads 0x1; CORE_DONE with RESULT 0x0000002A -> STATUS 0x2, RESULT 0x2A, IRQ=1; write STATUS 0x2 -> IRQ=0.
REQ-039 START while BUSY -> no CORE_START; buffer write while BUSY -> read returns previous value.
REQ-040 Reads every cycle addresses 0..5 and DEPTH+3 -> six valid responses in order then 0 for unmapped.
REQ-041 CORE_DONE and DONE W1C same cycle -> DONE=1; RESET asserted mid-BUSY asynchronously -> all outputs 0 immediately, STATUS 0.
